// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-to-ALU command controller.
//   state_t        : controller FSM state encoding
//   *_BYTE_DEF     : default frame marker / status byte values
//   FRAME_LEN      : number of bytes in a command frame (SYNC, OP, A, B, CHK)
//   sat_inc8       : saturating 8-bit increment used by the error counter
package uart_alu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_GET_OP    = 4'd1,
        ST_GET_A     = 4'd2,
        ST_GET_B     = 4'd3,
        ST_GET_CHK   = 4'd4,
        ST_LATCH     = 4'd5,
        ST_TX_STAT   = 4'd6,
        ST_WAIT_STAT = 4'd7,
        ST_TX_RES    = 4'd8,
        ST_WAIT_RES  = 4'd9
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] ACK_BYTE_DEF  = 8'h06;
    localparam logic [7:0] NAK_BYTE_DEF  = 8'h15;
    localparam int         FRAME_LEN     = 5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer. Counts baud ticks while enabled and raises a
// single-cycle timeout pulse once TIMEOUT_TICKS ticks have elapsed since
// the last clear.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   i_tick    : baud tick pulse
//   i_clear   : restart the count (entry into a frame / accepted byte)
//   i_enable  : count only while a frame is being received
//   o_timeout : one-cycle pulse when the gap limit is reached
module uart_gap_timer #(
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);

    localparam int            CW    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_TICKS);

    logic [CW-1:0] count_reg;
    logic          fired_reg;

    // The count parks at LIMIT; fired_reg keeps the pulse to a single cycle
    // even if the consumer stays enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            fired_reg <= 1'b0;
        end else if (i_clear || !i_enable) begin
            count_reg <= '0;
            fired_reg <= 1'b0;
        end else begin
            if (i_tick && (count_reg != LIMIT))
                count_reg <= count_reg + 1'b1;
            if (o_timeout)
                fired_reg <= 1'b1;
        end
    end

    assign o_timeout = i_enable && !fired_reg && (count_reg == LIMIT);

endmodule

// File: rtl/uart_alu_cmd_ctrl.sv
// Framed command controller between uart_rx/uart_tx and the ALU.
// Collects SYNC, OP, A, B, CHK; on a good XOR checksum commits OP/A/B to the
// ALU, then replies with STATUS (ACK/NAK) and RESULT bytes.
//   clk, reset          : system clock, asynchronous active-low reset
//   i_tick              : baud tick (drives the inter-byte gap timer)
//   i_rx_data/i_rx_valid: received byte and its one-cycle strobe
//   i_tx_done           : transmitter finished the current byte
//   i_alu_result        : combinational ALU output
//   o_tx_data/o_tx_start: byte to send and one-cycle send request
//   o_A, o_B, o_op      : operands/opcode of the last accepted frame
//   o_busy              : high whenever the FSM is not IDLE
//   o_err_count         : saturating count of timeouts + checksum failures
module uart_alu_cmd_ctrl
    import uart_alu_pkg::*;
#(
    parameter int             N             = 8,
    parameter int             TIMEOUT_TICKS = 640,
    parameter logic [N-1:0]   SYNC_BYTE     = N'(SYNC_BYTE_DEF),
    parameter logic [N-1:0]   ACK_BYTE      = N'(ACK_BYTE_DEF),
    parameter logic [N-1:0]   NAK_BYTE      = N'(NAK_BYTE_DEF)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_tick,
    input  logic [N-1:0] i_rx_data,
    input  logic         i_rx_valid,
    input  logic         i_tx_done,
    input  logic [N-1:0] i_alu_result,
    output logic [N-1:0] o_tx_data,
    output logic         o_tx_start,
    output logic [N-1:0] o_A,
    output logic [N-1:0] o_B,
    output logic [N-1:0] o_op,
    output logic         o_busy,
    output logic [7:0]   o_err_count
);

    state_t       state_reg, state_next;
    logic [N-1:0] op_s, a_s, b_s;
    logic [N-1:0] op_reg, a_reg, b_reg;
    logic [N-1:0] status_q, result_q;
    logic         ack_q;
    logic [7:0]   err_count_reg;

    logic         timer_enable, timer_clear, timeout;
    logic         frame_ok, frame_bad, timeout_err;
    logic [N-1:0] tx_data_next;
    logic         tx_start_next;

    // Timer control depends only on state and the rx strobe, never on the
    // timeout itself, so there is no combinational loop through the FSM.
    assign timer_enable = (state_reg == ST_GET_OP) || (state_reg == ST_GET_A) ||
                          (state_reg == ST_GET_B)  || (state_reg == ST_GET_CHK);
    assign timer_clear  = i_rx_valid &&
                          (timer_enable || ((state_reg == ST_IDLE) && (i_rx_data == SYNC_BYTE)));

    uart_gap_timer #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .i_tick   (i_tick),
        .i_clear  (timer_clear),
        .i_enable (timer_enable),
        .o_timeout(timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Next state and the transmit interface. A byte arriving in the same
    // cycle as a timeout takes priority.
    always_comb begin
        state_next    = state_reg;
        frame_ok      = 1'b0;
        frame_bad     = 1'b0;
        timeout_err   = 1'b0;
        tx_start_next = 1'b0;
        tx_data_next  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (i_rx_valid && (i_rx_data == SYNC_BYTE))
                    state_next = ST_GET_OP;
            end
            ST_GET_OP, ST_GET_A, ST_GET_B: begin
                if (i_rx_valid) begin
                    case (state_reg)
                        ST_GET_OP: state_next = ST_GET_A;
                        ST_GET_A:  state_next = ST_GET_B;
                        default:   state_next = ST_GET_CHK;
                    endcase
                end else if (timeout) begin
                    state_next  = ST_IDLE;
                    timeout_err = 1'b1;
                end
            end
            ST_GET_CHK: begin
                if (i_rx_valid) begin
                    state_next = ST_LATCH;
                    if (i_rx_data == (op_s ^ a_s ^ b_s))
                        frame_ok = 1'b1;
                    else
                        frame_bad = 1'b1;
                end else if (timeout) begin
                    state_next  = ST_IDLE;
                    timeout_err = 1'b1;
                end
            end
            ST_LATCH: begin
                state_next = ST_TX_STAT;
            end
            ST_TX_STAT: begin
                tx_start_next = 1'b1;
                tx_data_next  = status_q;
                state_next    = ST_WAIT_STAT;
            end
            ST_WAIT_STAT: begin
                tx_data_next = status_q;
                if (i_tx_done)
                    state_next = ST_TX_RES;
            end
            ST_TX_RES: begin
                tx_start_next = 1'b1;
                tx_data_next  = result_q;
                state_next    = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                tx_data_next = result_q;
                if (i_tx_done)
                    state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: shadows, committed ALU inputs, response bytes, errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_s          <= '0;
            a_s           <= '0;
            b_s           <= '0;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            status_q      <= '0;
            result_q      <= '0;
            ack_q         <= 1'b0;
            err_count_reg <= '0;
        end else begin
            if (i_rx_valid) begin
                if (state_reg == ST_GET_OP) op_s <= i_rx_data;
                if (state_reg == ST_GET_A)  a_s  <= i_rx_data;
                if (state_reg == ST_GET_B)  b_s  <= i_rx_data;
            end
            if (frame_ok) begin
                op_reg   <= op_s;
                a_reg    <= a_s;
                b_reg    <= b_s;
                status_q <= ACK_BYTE;
                ack_q    <= 1'b1;
            end
            if (frame_bad) begin
                status_q <= NAK_BYTE;
                ack_q    <= 1'b0;
            end
            // The ALU sees the newly committed operands one cycle after CHK.
            if (state_reg == ST_LATCH)
                result_q <= ack_q ? i_alu_result : '0;
            if (frame_bad || timeout_err)
                err_count_reg <= sat_inc8(err_count_reg);
        end
    end

    assign o_tx_data   = tx_data_next;
    assign o_tx_start  = tx_start_next;
    assign o_A         = a_reg;
    assign o_B         = b_reg;
    assign o_op        = op_reg;
    assign o_busy      = (state_reg != ST_IDLE);
    assign o_err_count = err_count_reg;

endmodule

// File: tb/tb_uart_alu_cmd_ctrl.sv
// Directed bench for uart_alu_cmd_ctrl. A frame-level model (expected TX byte
// queue, expected committed operands and error count) is compared against
// the DUT every cycle; literal checks pin latency and known results.
module tb_uart_alu_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_tick = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_valid = 1'b0;
    logic       resp_done = 1'b0;
    logic       inj_done = 1'b0;
    logic       i_tx_done;
    logic [7:0] alu_result;
    logic [7:0] o_tx_data, o_A, o_B, o_op, o_err_count;
    logic       o_tx_start, o_busy;

    always #5 clk = ~clk;

    assign i_tx_done = resp_done | inj_done;

    uart_alu_cmd_ctrl dut (
        .clk         (clk),
        .reset       (rst_n),
        .i_tick      (i_tick),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .i_tx_done   (i_tx_done),
        .i_alu_result(alu_result),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_A         (o_A),
        .o_B         (o_B),
        .o_op        (o_op),
        .o_busy      (o_busy),
        .o_err_count (o_err_count)
    );

    // Stand-in ALU attached to the committed outputs.
    function automatic logic [7:0] alu_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            8'h20:   return a + b;
            8'h22:   return a - b;
            8'h24:   return a & b;
            8'h25:   return a | b;
            8'h26:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_fn(o_op, o_A, o_B);

    // Frame-level model state
    logic [7:0] m_op = 8'h00, m_a = 8'h00, m_b = 8'h00, m_err = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] tx_log[$];
    int         vec_count = 0;
    int         miss_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare process, sampling 1 ns after the active edge.
    initial begin
        logic [7:0] cur;
        bit         in_flight;
        cur = 8'h00;
        in_flight = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                in_flight = 1'b0;
                check("rst_tx_start", o_tx_start, 0);
                check("rst_busy", o_busy, 0);
                check("rst_A", o_A, 0);
                check("rst_B", o_B, 0);
                check("rst_op", o_op, 0);
                check("rst_err", o_err_count, 0);
                check("rst_tx_data", o_tx_data, 0);
            end else begin
                if (o_tx_start) begin
                    vec_count++;
                    if (exp_q.size() == 0) begin
                        miss_count++;
                        $display("FAIL tx_start: got unexpected start with data %0h, expected none", o_tx_data);
                    end else begin
                        cur = exp_q.pop_front();
                        if (o_tx_data !== cur) begin
                            miss_count++;
                            $display("FAIL tx_byte: got %0h expected %0h", o_tx_data, cur);
                        end
                    end
                    tx_log.push_back(o_tx_data);
                    in_flight = 1'b1;
                end else if (in_flight && o_busy) begin
                    check("tx_hold", o_tx_data, cur);
                end
                if (!o_busy) begin
                    in_flight = 1'b0;
                    check("idle_op", o_op, m_op);
                    check("idle_A", o_A, m_a);
                    check("idle_B", o_B, m_b);
                    check("idle_err", o_err_count, m_err);
                end
            end
        end
    end

    // Transmitter stand-in: finishes each byte 3 cycles after its start.
    initial begin
        forever begin
            @(negedge clk);
            if (o_tx_start) begin
                do begin
                    repeat (3) @(negedge clk);
                    resp_done = 1'b1;
                    @(negedge clk);
                    resp_done = 1'b0;
                end while (o_tx_start);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] chk);
        if (chk == (op ^ a ^ b)) begin
            exp_q.push_back(8'h06);
            exp_q.push_back(alu_fn(op, a, b));
            m_op = op;
            m_a  = a;
            m_b  = b;
        end else begin
            exp_q.push_back(8'h15);
            exp_q.push_back(8'h00);
            m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
        end
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(op);
        send_byte(a);
        send_byte(b);
        model_frame(op, a, b, chk);
        send_byte(chk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((o_busy || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < 200), 1);
        @(negedge clk);
    endtask

    task automatic tick_cycles(input int n);
        i_tick = 1'b1;
        repeat (n) @(negedge clk);
        i_tick = 1'b0;
    endtask

    // Partial frame then silence: one tick short keeps the frame alive,
    // the 640th tick aborts it.
    task automatic do_timeout();
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h05);
        m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
        tick_cycles(639);
        check("to_busy_at_639", o_busy, 1);
        tick_cycles(1);
        @(negedge clk);
        check("to_busy_after", o_busy, 0);
        check("to_err", o_err_count, m_err);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", o_busy, 0);
        check("reset_err", o_err_count, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Valid ADD frame; pin latency from CHK to the status start.
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h05);
        send_byte(8'h03);
        model_frame(8'h20, 8'h05, 8'h03, 8'h26);
        send_byte(8'h26);
        check("t1_op", o_op, 8'h20);
        check("t1_A", o_A, 8'h05);
        check("t1_B", o_B, 8'h03);
        check("t1_start_latch", o_tx_start, 0);
        @(negedge clk);
        check("t1_start", o_tx_start, 1);
        check("t1_status", o_tx_data, 8'h06);
        wait_idle("t1_idle");
        check("t1_log0", tx_log[0], 8'h06);
        check("t1_log1", tx_log[1], 8'h08);
        check("t1_err", o_err_count, 8'h00);

        // Bad checksum: NAK, result 00, operands untouched.
        send_frame(8'h20, 8'h05, 8'h03, 8'h27);
        wait_idle("t2_idle");
        check("t2_log2", tx_log[2], 8'h15);
        check("t2_log3", tx_log[3], 8'h00);
        check("t2_A", o_A, 8'h05);
        check("t2_B", o_B, 8'h03);
        check("t2_op", o_op, 8'h20);
        check("t2_err", o_err_count, 8'h01);

        // Inter-byte timeout.
        do_timeout();
        check("t3_err", o_err_count, 8'h02);
        check("t3_log_size", tx_log.size(), 4);

        // Garbage before the frame is discarded silently.
        send_byte(8'h11);
        send_byte(8'h22);
        check("t4_busy_garbage", o_busy, 0);
        send_frame(8'h24, 8'hF0, 8'h3C, 8'hE8);
        wait_idle("t4_idle");
        check("t4_log4", tx_log[4], 8'h06);
        check("t4_log5", tx_log[5], 8'h30);
        check("t4_err", o_err_count, 8'h02);

        // rx byte during WAIT_STAT and tx_done while IDLE are both ignored.
        send_frame(8'h25, 8'h0A, 8'h50, 8'h7F);
        @(negedge clk);
        send_byte(8'hA5);
        wait_idle("t5_idle");
        check("t5_busy", o_busy, 0);
        @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        @(negedge clk);
        check("t5_busy_done", o_busy, 0);
        check("t5_log6", tx_log[6], 8'h06);
        check("t5_log7", tx_log[7], 8'h5A);
        check("t5_log_size", tx_log.size(), 8);

        // Reset during GET_B, then a fresh SUB frame.
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h07);
        @(negedge clk);
        m_op = 8'h00; m_a = 8'h00; m_b = 8'h00; m_err = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_err", o_err_count, 8'h00);
        check("t6_rst_op", o_op, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h22, 8'h09, 8'h04, 8'h2F);
        wait_idle("t6_idle");
        check("t6_log8", tx_log[8], 8'h06);
        check("t6_log9", tx_log[9], 8'h05);
        check("t6_op", o_op, 8'h22);
        check("t6_err", o_err_count, 8'h00);

        // Drive the error counter to saturation, then push past it.
        while (m_err != 8'hFF) begin
            send_frame(8'h26, 8'h01, 8'h02, 8'h00);
            wait_idle("t7_nak_idle");
        end
        check("t7_err_ff", o_err_count, 8'hFF);
        do_timeout();
        check("t7_err_ff_to", o_err_count, 8'hFF);
        send_frame(8'h26, 8'h01, 8'h02, 8'h00);
        wait_idle("t7_last_idle");
        check("t7_err_ff_nak", o_err_count, 8'hFF);
        check("t7_op_kept", o_op, 8'h22);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
